// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer wrap arithmetic that does
// not rely on power-of-two depths.
package sync_fifo_pkg;

  // Advance a ring pointer, wrapping DEPTH-1 -> 0 by explicit compare.
  function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, DEPTH x WIDTH, with registered-read or first-word-fallthrough
// output timing. Flags derive from a registered occupancy count only.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 8,
  parameter bit FIRST_WORD_FALLTHROUGH = 1'b0,
  parameter bit DEBUG                  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             wr_acc, rd_acc;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // FWFT exposes the head entry directly; its value is meaningless while empty.
  assign dout = FIRST_WORD_FALLTHROUGH ? mem_q[rd_ptr_q] : dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = PW'(wrap_inc(32'(wr_ptr_q), 32'(DEPTH)));
    if (rd_acc) begin
      rd_ptr_d = PW'(wrap_inc(32'(rd_ptr_q), 32'(DEPTH)));
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; gating on rst keeps reset dominant over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= din;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (DEBUG && !rst) begin
      if (wr_acc)          $display("[sync_fifo] push %0h", din);
      if (rd_acc)          $display("[sync_fifo] pop  %0h", mem_q[rd_ptr_q]);
      if (wr_en && full)   $display("[sync_fifo] overflow attempt dropped");
      if (rd_en && empty)  $display("[sync_fifo] underflow attempt ignored");
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo: a queue model decides acceptance,
// a negedge monitor checks flags, registered dout and fallthrough dout.
module tb_sync_fifo;
  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0] din = '0;
  logic         full, empty, f_full, f_empty;
  logic [W-1:0] dout, f_dout;

  sync_fifo #(.WIDTH(W), .DEPTH(D), .FIRST_WORD_FALLTHROUGH(1'b0), .DEBUG(1'b0)) u_reg (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty));

  sync_fifo #(.WIDTH(W), .DEPTH(D), .FIRST_WORD_FALLTHROUGH(1'b1), .DEBUG(1'b0)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(f_full),
    .rd_en(rd_en), .dout(f_dout), .empty(f_empty));

  always #5 clk = ~clk;

  logic [W-1:0] mq[$];   // model contents, head at index 0
  logic [W-1:0] eq[$];   // expected registered dout responses
  logic [W-1:0] last_exp = '0;
  bit           mon_on = 1'b0;
  int           n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update the model at the following posedge.
  task automatic cyc(input bit r, input bit w, input bit rd, input logic [W-1:0] d);
    bit wa, ra;
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      eq.delete();
      eq.push_back('0);
      mon_on = 1'b1;
    end else begin
      wa = w && (mq.size() < D);
      ra = rd && (mq.size() > 0);
      if (ra) eq.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (eq.size() > 0) last_exp = eq.pop_front();
        chk("dout",    32'(dout),    32'(last_exp));
        chk("empty",   32'(empty),   32'(mq.size() == 0));
        chk("full",    32'(full),    32'(mq.size() == D));
        chk("f_empty", 32'(f_empty), 32'(mq.size() == 0));
        chk("f_full",  32'(f_full),  32'(mq.size() == D));
        if (mq.size() > 0) chk("f_dout", 32'(f_dout), 32'(mq[0]));
      end
    end
  end

  initial begin
    // Reset held two cycles with request pulses that must be ignored.
    cyc(1, 1, 1, 8'h33);
    cyc(1, 1, 1, 8'h44);
    // Fill then one overflow attempt.
    for (int i = 1; i <= D; i++) cyc(0, 1, 0, W'(i));
    cyc(0, 1, 0, 8'hFF);
    // Drain plus one underflow attempt (dout must hold the last word).
    for (int i = 0; i <= D; i++) cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    // Random streaming including over/underflow attempts and wrap.
    for (int i = 0; i < 128; i++)
      cyc(0, ($urandom % 4) != 0, ($urandom % 4) != 0, W'($urandom));
    // Simultaneous read and write while full: write dropped, count drops to D-1.
    while (mq.size() < D) cyc(0, 1, 0, W'($urandom));
    cyc(0, 1, 1, 8'hAA);
    while (mq.size() > 0) cyc(0, 0, 1, 8'h00);
    // Reset mid-stream discards contents.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, W'(8'h10 + i));
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    // Fallthrough: word visible without rd_en, then popped.
    cyc(0, 1, 0, 8'h5A);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h00);
    cyc(0, 0, 0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    chk("end_empty", 32'(mq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
